// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, line-level
// constants and the parity helper.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    // Parity bit given the XOR-reduction of the word and the parity type.
    function automatic logic parity_bit(input logic i_xor_red, input logic i_par_typ);
        return (i_par_typ == PAR_ODD) ? ~i_xor_red : i_xor_red;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Shift/hold register plus bit counter for the UART transmitter. o_bit is the
// next data bit to put on the line; each shift consumes one bit.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_shift,
    output logic                  o_bit,
    output logic                  o_last_bit
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_cnt   <= '0;
        end else if (i_shift) begin
            r_shift <= r_shift >> 1;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    assign o_bit      = r_shift[0];
    // The counter is one ahead of the bit on the line, since the shift happens
    // on the edge that puts the bit out: data bit i is on the line while r_cnt == i+1.
    assign o_last_bit = (r_cnt == CW'(DATA_WIDTH));

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one bit per baud clock, frame = start, data LSB-first,
// optional parity, stop. Back-to-back frames are accepted on the stop-bit exit edge.
module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);

    tx_state_e r_state;
    logic      r_tx;
    logic      r_busy;
    logic      r_par_en;
    logic      r_par_bit;

    logic      w_load;
    logic      w_shift;
    logic      w_bit;
    logic      w_last;

    // A new word is only accepted when the line is free or finishing its stop bit.
    assign w_load  = data_valid && ((r_state == IDLE) || (r_state == STOP));
    assign w_shift = (r_state == START) || ((r_state == DATA) && !w_last);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_data     (p_data),
        .i_shift    (w_shift),
        .o_bit      (w_bit),
        .o_last_bit (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_tx      <= STOP_BIT;
            r_busy    <= 1'b0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else begin
            case (r_state)
                IDLE, STOP: begin
                    if (data_valid) begin
                        // Parity is fixed from the word at the moment it is latched.
                        r_state   <= START;
                        r_tx      <= START_BIT;
                        r_busy    <= 1'b1;
                        r_par_en  <= par_en;
                        r_par_bit <= parity_bit(^p_data, par_typ);
                    end else begin
                        r_state <= IDLE;
                        r_tx    <= STOP_BIT;
                        r_busy  <= 1'b0;
                    end
                end
                START: begin
                    r_state <= DATA;
                    r_tx    <= w_bit;
                end
                DATA: begin
                    if (w_last) begin
                        if (r_par_en) begin
                            r_state <= PARITY;
                            r_tx    <= r_par_bit;
                        end else begin
                            r_state <= STOP;
                            r_tx    <= STOP_BIT;
                        end
                    end else begin
                        r_tx <= w_bit;
                    end
                end
                PARITY: begin
                    r_state <= STOP;
                    r_tx    <= STOP_BIT;
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= STOP_BIT;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_out = r_tx;
    assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: table of frames with hand-computed line
// sequences, plus back-to-back, mid-frame strobe and mid-frame reset sequences.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] p_data = 8'h00;
    logic       data_valid = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       tx_out;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        string      frame;   // expected tx_out per cycle, in time order
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b", nm, act, exp);
        end
    endtask

    task automatic chk_line(input string nm, input logic exp_tx, input logic exp_busy);
        chk({nm, ".tx"}, tx_out, exp_tx);
        chk({nm, ".busy"}, busy, exp_busy);
    endtask

    function automatic logic bit_of(input string s, input int i);
        return (s.getc(i) == 8'h31);
    endfunction

    // Called at a negedge; the following posedge samples the strobe.
    task automatic strobe(input logic [7:0] d, input logic pe, input logic pt);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    initial begin
        string s;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, "0101001011"};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, "01010010101"};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, "01010010111"};
        vecs[3] = '{8'h07, 1'b1, 1'b0, "01110000011"};
        vecs[4] = '{8'h3C, 1'b0, 1'b0, "0001111001"};

        // Reset held for 3 cycles, then 20 idle cycles.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_line($sformatf("reset[%0d]", i), 1'b1, 1'b0);
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_line($sformatf("idle[%0d]", i), 1'b1, 1'b0);
        end

        // Table frames; inputs are scrambled mid-frame and must not matter.
        foreach (vecs[v]) begin
            strobe(vecs[v].data, vecs[v].pe, vecs[v].pt);
            p_data  = ~vecs[v].data;
            par_en  = ~vecs[v].pe;
            par_typ = ~vecs[v].pt;
            for (int i = 0; i < vecs[v].frame.len(); i++) begin
                chk_line($sformatf("vec%0d[%0d]", v, i), bit_of(vecs[v].frame, i), 1'b1);
                @(negedge clk);
            end
            chk_line($sformatf("vec%0d.end", v), 1'b1, 1'b0);
            @(negedge clk);
        end

        // Back-to-back: 0xFF strobed on the STOP exit edge of the 0x00 frame.
        s = "00000000010111111111";
        strobe(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            chk_line($sformatf("b2b[%0d]", i), bit_of(s, i), 1'b1);
            if (i == 9) begin
                p_data     = 8'hFF;
                data_valid = 1'b1;
            end else begin
                data_valid = 1'b0;
            end
            @(negedge clk);
        end
        data_valid = 1'b0;
        chk_line("b2b.end", 1'b1, 1'b0);
        @(negedge clk);

        // Strobe of 0x3C during the 0x81 frame is dropped.
        s = "0100000011";
        strobe(8'h81, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk_line($sformatf("drop[%0d]", i), bit_of(s, i), 1'b1);
            if (i == 3) begin
                p_data     = 8'h3C;
                data_valid = 1'b1;
            end else begin
                data_valid = 1'b0;
            end
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            chk_line($sformatf("drop.idle[%0d]", i), 1'b1, 1'b0);
            @(negedge clk);
        end

        // Reset during DATA bit 3 of 0x55, then a clean 0x55 frame.
        s = "0101010101";
        strobe(8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk_line($sformatf("rstmid[%0d]", i), bit_of(s, i), 1'b1);
            if (i == 4) rst = 1'b0;
            @(negedge clk);
        end
        chk_line("rstmid.abort", 1'b1, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_line($sformatf("rstmid.idle[%0d]", i), 1'b1, 1'b0);
        end
        strobe(8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk_line($sformatf("rstmid.re[%0d]", i), bit_of(s, i), 1'b1);
            @(negedge clk);
        end
        chk_line("rstmid.re.end", 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
